// File: rtl/ball_motion_if.sv
// Control and position bundle between the frame source,
// the motion controller and the shape renderer.
interface ball_motion_if;
  logic       frame_tick;
  logic       start;
  logic       pause;
  logic [2:0] speed;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic       bounce_x;
  logic       bounce_y;
  logic       running;

  modport master (
    output frame_tick, start, pause, speed,
    input  ball_x, ball_y, dir_x, dir_y,
    input  bounce_x, bounce_y, running
  );

  modport slave (
    input  frame_tick, start, pause, speed,
    output ball_x, ball_y, dir_x, dir_y,
    output bounce_x, bounce_y, running
  );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous bouncing-ball position generator.
// Position moves between frames only, clamped at the walls.
module ball_motion_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int RADIUS    = 100,
  parameter int X_INIT    = 320,
  parameter int Y_INIT    = 240,
  parameter int FRAME_DIV = 1
) (
  input logic          clk,
  input logic          reset,
  ball_motion_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam int CW =
    (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(FRAME_DIV - 1);

  localparam logic [10:0] X_MIN =
    11'(RADIUS);
  localparam logic [10:0] X_MAX =
    11'(H_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] Y_MIN =
    11'(RADIUS);
  localparam logic [10:0] Y_MAX =
    11'(V_ACTIVE - 1 - RADIUS);

  // Result packing: {bounce, dir, pos[9:0]}
  function automatic logic [11:0] axis_next(
    input logic [9:0]  pos,
    input logic        dir,
    input logic [2:0]  spd,
    input logic [10:0] lo,
    input logic [10:0] hi
  );
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] up;
    logic [10:0] dn;
    logic [10:0] lim;
    p   = {1'b0, pos};
    s   = {8'd0, spd};
    up  = p + s;
    dn  = p - s;
    lim = lo + s;
    if (dir) begin
      if (up >= hi)
        axis_next = {1'b1, 1'b0, hi[9:0]};
      else
        axis_next = {1'b0, 1'b1, up[9:0]};
    end else begin
      if (p <= lim)
        axis_next = {1'b1, 1'b1, lo[9:0]};
      else
        axis_next = {1'b0, 1'b0, dn[9:0]};
    end
  endfunction

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic          r_dx;
  logic          r_dy;
  logic          r_bx;
  logic          r_by;
  logic          r_run;
  logic          w_tick_run;
  logic          w_step;
  logic [11:0]   w_nx;
  logic [11:0]   w_ny;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (bus.start)
          w_state_nxt = bus.pause ? S_PAUSE : S_RUN;
      S_RUN:
        if (bus.pause) w_state_nxt = S_PAUSE;
      S_PAUSE:
        if (!bus.pause) w_state_nxt = S_RUN;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  // A tick coinciding with pause is dropped, not deferred
  assign w_tick_run = bus.frame_tick && !bus.pause &&
                      (r_state == S_RUN);
  assign w_step = w_tick_run && (r_cnt == CNT_LAST);

  assign w_nx = axis_next(r_x, r_dx, bus.speed,
                          X_MIN, X_MAX);
  assign w_ny = axis_next(r_y, r_dy, bus.speed,
                          Y_MIN, Y_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= 10'(X_INIT);
      r_y     <= 10'(Y_INIT);
      r_dx    <= 1'b1;
      r_dy    <= 1'b1;
      r_bx    <= 1'b0;
      r_by    <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= (w_state_nxt == S_RUN);
      r_bx    <= 1'b0;
      r_by    <= 1'b0;
      if (w_tick_run)
        r_cnt <= w_step ? '0 : r_cnt + 1'b1;
      if (w_step) begin
        r_x  <= w_nx[9:0];
        r_dx <= w_nx[10];
        r_bx <= w_nx[11];
        r_y  <= w_ny[9:0];
        r_dy <= w_ny[10];
        r_by <= w_ny[11];
      end
    end
  end

  assign bus.ball_x   = r_x;
  assign bus.ball_y   = r_y;
  assign bus.dir_x    = r_dx;
  assign bus.dir_y    = r_dy;
  assign bus.bounce_x = r_bx;
  assign bus.bounce_y = r_by;
  assign bus.running  = r_run;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: default, corner
// and frame-divider instances share one clock and reset.
module tb_ball_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ball_motion_if ia();
  ball_motion_if ic();
  ball_motion_if id();

  ball_motion_ctrl u_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ia)
  );

  ball_motion_ctrl #(
    .X_INIT (439),
    .Y_INIT (279)
  ) u_c (
    .clk   (clk),
    .reset (rst),
    .bus   (ic)
  );

  ball_motion_ctrl #(
    .FRAME_DIV (4)
  ) u_d (
    .clk   (clk),
    .reset (rst),
    .bus   (id)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] e
  );
    total++;
    if (obs !== e) begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d",
             tag, obs, e);
    end
  endtask

  task automatic tick_a();
    @(negedge clk); ia.frame_tick = 1'b1;
    @(negedge clk); ia.frame_tick = 1'b0;
  endtask

  task automatic tick_c();
    @(negedge clk); ic.frame_tick = 1'b1;
    @(negedge clk); ic.frame_tick = 1'b0;
  endtask

  task automatic tick_d();
    @(negedge clk); id.frame_tick = 1'b1;
    @(negedge clk); id.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    ia.start = 1'b0; ic.start = 1'b0;
    id.start = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    ia.frame_tick = 0; ia.start = 0;
    ia.pause = 0;      ia.speed = 0;
    ic.frame_tick = 0; ic.start = 0;
    ic.pause = 0;      ic.speed = 0;
    id.frame_tick = 0; id.start = 0;
    id.pause = 0;      id.speed = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_x", ia.ball_x, 320);
    chk("rst_y", ia.ball_y, 240);
    chk("rst_dx", ia.dir_x, 1);
    chk("rst_dy", ia.dir_y, 1);
    chk("rst_run", ia.running, 0);
    ia.speed = 3'd3;
    repeat (5) tick_a();
    chk("idle_x", ia.ball_x, 320);
    chk("idle_y", ia.ball_y, 240);
    chk("idle_run", ia.running, 0);
    chk("idle_bx", ia.bounce_x, 0);
    chk("idle_by", ia.bounce_y, 0);

    ia.speed = 3'd1;
    ia.start = 1'b1;
    @(negedge clk);
    chk("run_on", ia.running, 1);
    repeat (10) tick_a();
    chk("s1_x", ia.ball_x, 330);
    chk("s1_y", ia.ball_y, 250);

    do_reset();
    ia.speed = 3'd7;
    ia.start = 1'b1;
    @(negedge clk);
    repeat (19) tick_a();
    chk("s19_y", ia.ball_y, 373);
    chk("s19_by", ia.bounce_y, 0);
    tick_a();
    chk("s20_y", ia.ball_y, 379);
    chk("s20_dy", ia.dir_y, 0);
    chk("s20_by", ia.bounce_y, 1);
    chk("s20_bx", ia.bounce_x, 0);
    chk("s20_x", ia.ball_x, 460);
    @(negedge clk);
    chk("s20_by_clr", ia.bounce_y, 0);
    tick_a();
    chk("s21_y", ia.ball_y, 372);
    repeat (10) tick_a();
    chk("s31_x", ia.ball_x, 537);
    tick_a();
    chk("s32_x", ia.ball_x, 539);
    chk("s32_dx", ia.dir_x, 0);
    chk("s32_bx", ia.bounce_x, 1);
    chk("s32_y", ia.ball_y, 295);
    @(negedge clk);
    chk("s32_bx_clr", ia.bounce_x, 0);

    do_reset();
    ic.speed = 3'd1;
    ic.start = 1'b1;
    @(negedge clk);
    repeat (99) tick_c();
    chk("c99_x", ic.ball_x, 538);
    chk("c99_bx", ic.bounce_x, 0);
    tick_c();
    chk("c100_x", ic.ball_x, 539);
    chk("c100_y", ic.ball_y, 379);
    chk("c100_bx", ic.bounce_x, 1);
    chk("c100_by", ic.bounce_y, 1);
    tick_c();
    chk("c101_x", ic.ball_x, 538);
    chk("c101_y", ic.ball_y, 378);
    chk("c101_dx", ic.dir_x, 0);
    chk("c101_dy", ic.dir_y, 0);

    do_reset();
    id.speed = 3'd2;
    id.start = 1'b1;
    @(negedge clk);
    repeat (3) tick_d();
    chk("d3_x", id.ball_x, 320);
    tick_d();
    chk("d4_x", id.ball_x, 322);
    chk("d4_y", id.ball_y, 242);
    repeat (2) tick_d();
    chk("d6_x", id.ball_x, 322);
    @(negedge clk);
    id.pause = 1'b1;
    id.frame_tick = 1'b1;
    @(negedge clk);
    id.frame_tick = 1'b0;
    chk("dp_x", id.ball_x, 322);
    chk("dp_run", id.running, 0);
    repeat (6) tick_d();
    chk("dp6_x", id.ball_x, 322);
    id.pause = 1'b0;
    @(negedge clk);
    chk("dres_run", id.running, 1);
    tick_d();
    chk("dr1_x", id.ball_x, 322);
    tick_d();
    chk("dr2_x", id.ball_x, 324);
    chk("dr2_y", id.ball_y, 244);

    do_reset();
    ia.speed = 3'd4;
    ia.start = 1'b1;
    @(negedge clk);
    repeat (20) tick_a();
    chk("m_x", ia.ball_x, 400);
    chk("m_y", ia.ball_y, 320);
    #2 rst = 1'b1;
    #1;
    chk("ar_x", ia.ball_x, 320);
    chk("ar_y", ia.ball_y, 240);
    chk("ar_dx", ia.dir_x, 1);
    chk("ar_dy", ia.dir_y, 1);
    chk("ar_run", ia.running, 0);
    ia.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick_a();
    chk("ar_idle_x", ia.ball_x, 320);
    chk("ar_idle_run", ia.running, 0);
    ia.start = 1'b1;
    @(negedge clk);
    tick_a();
    chk("ar_go_x", ia.ball_x, 324);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
